// File: rtl/pulse_meter_if.sv
// Bundles the measurement request, signal and result handshake of pulse_meter.
// The master side (consumer) drives the request/ack lines and the measured signal;
// the slave side (pulse_meter) returns the captured count and its status flags.
interface pulse_meter_if #(
  parameter int WIDTH = 32
);
  logic             sig;
  logic             mode;
  logic             arm;
  logic             ack;
  logic             clr;
  logic [WIDTH-1:0] q;
  logic             vld;
  logic             ovf;
  logic             busy;

  modport master (
    output sig, mode, arm, ack, clr,
    input  q, vld, ovf, busy
  );

  modport slave (
    input  sig, mode, arm, ack, clr,
    output q, vld, ovf, busy
  );
endinterface

// File: rtl/pulse_meter.sv
// Cycle-accurate interval meter. The measured signal is synchronised by a
// two-flop chain with a third flop holding the previous synchronised value.
// Once armed, the first rise starts the count. The terminating edge then
// freezes the count into q and raises vld. The terminating edge is a fall in
// pulse-width mode and the next rise in period mode. Start and end edges see
// the same two-cycle synchroniser latency, so q is the true interval in clk
// cycles. The counter saturates rather than wrapping.
module pulse_meter #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst,
  pulse_meter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state;
  logic             s1;
  logic             s2;
  logic             s3;
  logic             rise;
  logic             fall;
  logic             end_edge;
  logic             mode_r;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] q_r;
  logic             vld_r;
  logic             ovf_r;
  logic             busy_r;

  // Bring sig into the clk domain and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= bus.sig;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise     = s2 & ~s3;
  assign fall     = ~s2 & s3;
  assign end_edge = mode_r ? rise : fall;

  // Measurement FSM: arm, wait for the start rise, count, then hold the result until acknowledged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      mode_r <= 1'b0;
      cnt    <= '0;
      q_r    <= '0;
      vld_r  <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
    end else if (bus.clr) begin
      state  <= IDLE;
      cnt    <= '0;
      q_r    <= '0;
      vld_r  <= 1'b0;
      ovf_r  <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.arm) begin
            state  <= ARMED;
            mode_r <= bus.mode;
            busy_r <= 1'b1;
          end
        end
        ARMED: begin
          if (rise) begin
            state <= MEASURE;
            cnt   <= {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        MEASURE: begin
          if (end_edge) begin
            state  <= DONE;
            q_r    <= cnt;
            ovf_r  <= (cnt == ALL_ONES);
            vld_r  <= 1'b1;
            busy_r <= 1'b0;
          end else if (cnt != ALL_ONES) begin
            cnt <= cnt + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        DONE: begin
          if (bus.ack) begin
            vld_r <= 1'b0;
            if (bus.arm) begin
              state  <= ARMED;
              mode_r <= bus.mode;
              busy_r <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
          vld_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.q    = q_r;
  assign bus.vld  = vld_r;
  assign bus.ovf  = ovf_r;
  assign bus.busy = busy_r;

endmodule

// File: tb/tb_pulse_meter.sv
// Bench for pulse_meter: a 32-bit and a 4-bit instance share one stimulus
// stream. Expected results come from a waveform-level model that replays the
// recorded sig samples against the arm point and the mode.
module tb_pulse_meter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic sig = 1'b0;
  logic mode = 1'b0;
  logic arm = 1'b0;
  logic ack = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  pulse_meter_if #(.WIDTH(32)) pm32 ();
  pulse_meter_if #(.WIDTH(4))  pm4 ();

  assign pm32.sig  = sig;
  assign pm32.mode = mode;
  assign pm32.arm  = arm;
  assign pm32.ack  = ack;
  assign pm32.clr  = clr;
  assign pm4.sig   = sig;
  assign pm4.mode  = mode;
  assign pm4.arm   = arm;
  assign pm4.ack   = ack;
  assign pm4.clr   = clr;

  pulse_meter #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(pm32.slave));
  pulse_meter #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(pm4.slave));

  int   compared = 0;
  int   mismatched = 0;
  int   cyc;
  logic sigHist [0:16383];
  bit   wave [$];
  logic vldPrev = 1'b0;
  int   vldRiseEdge = -1;

  // Record the sig value seen at every clk edge since the last reset release.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else begin
      sigHist[cyc[13:0]] <= sig;
      cyc <= cyc + 1;
    end
  end

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
    if (pm32.vld === 1'b1 && !vldPrev) vldRiseEdge = cyc - 1;
    vldPrev = (pm32.vld === 1'b1);
  endtask

  function automatic bit sampleAt(input int k);
    return (k >= 0) && (sigHist[k[13:0]] === 1'b1);
  endfunction

  function automatic bit isRise(input int k);
    return sampleAt(k) && !sampleAt(k - 1);
  endfunction

  function automatic bit isFall(input int k);
    return !sampleAt(k) && sampleAt(k - 1);
  endfunction

  function automatic longint satQ(input longint iv, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (iv >= m) ? m : iv;
  endfunction

  // A transition sampled at edge k acts at edge k+2; the start rise counts only if it acts after the arm edge.
  task automatic refMeasure(input int armEdge, input bit md, output bit found, output int startK, output int endK);
    int last;
    last = cyc - 1;
    startK = -1;
    endK = -1;
    for (int k = (armEdge > 2 ? armEdge - 2 : 0); k + 2 <= last && startK < 0; k++)
      if (isRise(k) && k + 2 > armEdge) startK = k;
    if (startK >= 0)
      for (int k = startK + 1; k + 2 <= last && endK < 0; k++)
        if (md ? isRise(k) : isFall(k)) endK = k;
    found = (endK >= 0);
  endtask

  task automatic buildWave(input int p, input int dl, input int h, input int l);
    wave.delete();
    repeat (p) wave.push_back(1'b0);
    if (dl > 0) begin
      repeat (dl) wave.push_back(1'b1);
      wave.push_back(1'b0);
    end
    repeat (h) wave.push_back(1'b1);
    repeat (l) wave.push_back(1'b0);
    repeat (h) wave.push_back(1'b1);
    repeat (4) wave.push_back(1'b0);
  endtask

  // Play the wave (arming at index ai, or relying on an earlier arm at armEdgeIn) and check the result.
  task automatic applyStimulus(input int ai, input bit md, input int armEdgeIn);
    int     armEdge;
    bit     found;
    int     sK;
    int     eK;
    longint iv;
    armEdge = armEdgeIn;
    vldRiseEdge = -1;
    for (int i = 0; i < wave.size(); i++) begin
      sig = wave[i];
      arm = (i == ai);
      if (i == ai) begin
        mode = md;
        armEdge = cyc;
      end
      stepCycle();
      arm = 1'b0;
      if (i == ai) checkOutput("busy_after_arm", longint'(pm32.busy), 64'd1);
    end
    refMeasure(armEdge, md, found, sK, eK);
    if (!found) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ref_window: no complete interval found after arm edge %0d", armEdge);
    end else begin
      iv = longint'(eK - sK);
      checkOutput("vld32", longint'(pm32.vld), 64'd1);
      checkOutput("vld4", longint'(pm4.vld), 64'd1);
      checkOutput("q32", longint'(pm32.q), satQ(iv, 32));
      checkOutput("q4", longint'(pm4.q), satQ(iv, 4));
      checkOutput("ovf32", longint'(pm32.ovf), longint'(iv >= 64'd4294967295));
      checkOutput("ovf4", longint'(pm4.ovf), longint'(iv >= 64'd15));
      checkOutput("busy32_done", longint'(pm32.busy), 64'd0);
      checkOutput("busy4_done", longint'(pm4.busy), 64'd0);
      checkOutput("vld_edge", longint'(vldRiseEdge), longint'(eK + 2));
    end
  endtask

  task automatic finishResult(input bit bb, input bit nm, output int armEdge);
    int w;
    w = $urandom_range(0, 2);
    repeat (w) stepCycle();
    checkOutput("vld_hold", longint'(pm32.vld), 64'd1);
    ack = 1'b1;
    arm = bb;
    mode = nm;
    armEdge = cyc;
    stepCycle();
    ack = 1'b0;
    arm = 1'b0;
    checkOutput("vld32_after_ack", longint'(pm32.vld), 64'd0);
    checkOutput("vld4_after_ack", longint'(pm4.vld), 64'd0);
    checkOutput("busy_after_ack", longint'(pm32.busy), longint'(bb));
  endtask

  localparam int ND = 11;
  localparam int NR = 45;
  int dMode [ND] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
  int dP    [ND] = '{5, 2, 1, 1, 0, 1, 0, 0, 1, 1, 0};
  int dD    [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4};
  int dA    [ND] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2};
  int dH    [ND] = '{10, 3, 20, 3, 5, 2, 1, 1, 15, 14, 6};
  int dL    [ND] = '{4, 4, 3, 5, 2, 3, 1, 1, 2, 2, 3};

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit pre;
    bit preMode;
    int preEdge;
    pre = 1'b0;
    preMode = 1'b0;
    preEdge = 0;

    repeat (3) @(negedge clk);
    checkOutput("rst_q32", longint'(pm32.q), 64'd0);
    checkOutput("rst_vld", longint'(pm32.vld), 64'd0);
    checkOutput("rst_ovf", longint'(pm32.ovf), 64'd0);
    checkOutput("rst_busy", longint'(pm32.busy), 64'd0);
    checkOutput("rst_q4", longint'(pm4.q), 64'd0);
    rst = 1'b1;
    repeat (4) stepCycle();

    for (int t = 0; t < ND + NR; t++) begin
      bit md;
      bit bb;
      bit nm;
      int p;
      int dl;
      int ai;
      int h;
      int l;
      if (t < ND) begin
        md = bit'(dMode[t]);
        p = dP[t]; dl = dD[t]; ai = dA[t]; h = dH[t]; l = dL[t];
        bb = (t == 4);
      end else begin
        md = bit'($urandom_range(0, 1));
        p = $urandom_range(0, 3);
        dl = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 4) : 0;
        ai = $urandom_range(0, p + dl);
        h = $urandom_range(1, 20);
        l = $urandom_range(1, 6);
        bb = ($urandom_range(0, 3) == 0);
      end
      if (pre) begin
        md = preMode;
        ai = -1;
        dl = 0;
      end
      if (t == ND + NR - 1) bb = 1'b0;
      nm = (t + 1 < ND) ? bit'(dMode[t + 1]) : bit'($urandom_range(0, 1));
      buildWave(p, dl, h, l);
      applyStimulus(ai, md, preEdge);
      finishResult(bb, nm, preEdge);
      pre = bb;
      preMode = nm;
    end

    // Abort in the 4th MEASURE cycle; the later fall must not produce a result.
    arm = 1'b1; mode = 1'b0; sig = 1'b0;
    stepCycle();
    arm = 1'b0; sig = 1'b1;
    repeat (6) stepCycle();
    checkOutput("busy_before_clr", longint'(pm32.busy), 64'd1);
    clr = 1'b1;
    stepCycle();
    clr = 1'b0;
    checkOutput("clr_busy", longint'(pm32.busy), 64'd0);
    checkOutput("clr_q32", longint'(pm32.q), 64'd0);
    checkOutput("clr_q4", longint'(pm4.q), 64'd0);
    checkOutput("clr_vld", longint'(pm32.vld), 64'd0);
    sig = 1'b0;
    repeat (8) stepCycle();
    checkOutput("clr_no_vld", longint'(pm32.vld), 64'd0);
    checkOutput("clr_idle", longint'(pm32.busy), 64'd0);

    // Leave a nonzero result behind, then reset asynchronously with cnt at 6.
    buildWave(0, 0, 4, 2);
    applyStimulus(0, 1'b0, 0);
    finishResult(1'b0, 1'b0, preEdge);
    arm = 1'b1; mode = 1'b0; sig = 1'b0;
    stepCycle();
    arm = 1'b0; sig = 1'b1;
    repeat (8) stepCycle();
    checkOutput("busy_before_rst", longint'(pm32.busy), 64'd1);
    #2 rst = 1'b0;
    #1;
    checkOutput("arst_q32", longint'(pm32.q), 64'd0);
    checkOutput("arst_vld", longint'(pm32.vld), 64'd0);
    checkOutput("arst_busy", longint'(pm32.busy), 64'd0);
    checkOutput("arst_ovf", longint'(pm32.ovf), 64'd0);
    checkOutput("arst_busy4", longint'(pm4.busy), 64'd0);
    @(negedge clk);
    vldPrev = 1'b0;
    rst = 1'b1;
    wave.delete();
    repeat (8) wave.push_back(1'b1);
    repeat (5) wave.push_back(1'b0);
    applyStimulus(1, 1'b0, 0);
    finishResult(1'b0, 1'b0, preEdge);

    // Second release with sig high, armed too late for the spurious rise.
    sig = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vldPrev = 1'b0;
    rst = 1'b1;
    wave.delete();
    repeat (8) wave.push_back(1'b1);
    repeat (2) wave.push_back(1'b0);
    repeat (3) wave.push_back(1'b1);
    repeat (5) wave.push_back(1'b0);
    applyStimulus(4, 1'b0, 0);
    checkOutput("late_arm_q", longint'(pm32.q), 64'd3);
    finishResult(1'b0, 1'b0, preEdge);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
